// File: rtl/msg_sequencer.sv
// rtl/msg_sequencer.sv - game message sequencer: selects text message, level, blink and play/input gating
module msg_sequencer #(
  parameter int HOLD_FRAMES  = 90,
  parameter int BLINK_FRAMES = 30,
  parameter int MAX_LEVEL    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       seq_done,
  input  logic       user_done,
  input  logic       user_ok,
  output logic [2:0] state,
  output logic [2:0] level,
  output logic       match,
  output logic       text_en,
  output logic       play_req,
  output logic       input_en
);

  typedef enum logic [2:0] {
    READY  = 3'd0,
    SIMON  = 3'd1,
    USER   = 3'd2,
    RESULT = 3'd3,
    WIN    = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_MAX  = HOLD_FRAMES[7:0];
  localparam logic [7:0] BLINK_MAX = BLINK_FRAMES[7:0];
  localparam logic [2:0] LEVEL_MAX = MAX_LEVEL[2:0];

  state_t     state_q, state_n;
  logic [2:0] level_q, level_n;
  logic       match_q, match_n;
  logic       text_q, text_n;
  logic       play_q, play_n;
  logic       input_q, input_n;
  logic [7:0] hold_q, hold_n;
  logic [7:0] blink_q, blink_n;

  // State and every output are registered so no input reaches an output combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= READY;
      level_q <= 3'd0;
      match_q <= 1'b0;
      text_q  <= 1'b1;
      play_q  <= 1'b0;
      input_q <= 1'b0;
      hold_q  <= 8'd0;
      blink_q <= 8'd0;
    end else begin
      state_q <= state_n;
      level_q <= level_n;
      match_q <= match_n;
      text_q  <= text_n;
      play_q  <= play_n;
      input_q <= input_n;
      hold_q  <= hold_n;
      blink_q <= blink_n;
    end
  end

  // Next-state, counters and next output values; a tick on a transition edge only affects the old state
  always_comb begin
    state_n = state_q;
    level_n = level_q;
    match_n = match_q;
    text_n  = text_q;
    hold_n  = hold_q;
    blink_n = blink_q;

    case (state_q)
      READY, WIN: begin
        if (start) begin
          state_n = SIMON;
          level_n = 3'd0;
          match_n = 1'b0;
        end else if (frame_tick) begin
          if (blink_q + 8'd1 == BLINK_MAX) begin
            blink_n = 8'd0;
            text_n  = ~text_q;
          end else begin
            blink_n = blink_q + 8'd1;
          end
        end
      end
      SIMON: begin
        if (seq_done) state_n = USER;
      end
      USER: begin
        if (user_done) begin
          match_n = user_ok;
          hold_n  = 8'd0;
          state_n = RESULT;
        end
      end
      RESULT: begin
        if (frame_tick) begin
          hold_n = hold_q + 8'd1;
          if (hold_q + 8'd1 == HOLD_MAX) begin
            if (!match_q) begin
              state_n = READY;
            end else if (level_q >= LEVEL_MAX) begin
              state_n = WIN;
            end else begin
              level_n = level_q + 3'd1;
              state_n = SIMON;
            end
          end
        end
      end
      default: begin
        // Unused encodings recover to the full reset condition
        state_n = READY;
        level_n = 3'd0;
        match_n = 1'b0;
        hold_n  = 8'd0;
        blink_n = 8'd0;
        text_n  = 1'b1;
      end
    endcase

    // Entering any state restarts the blink phase with text visible
    if (state_n != state_q) begin
      blink_n = 8'd0;
      text_n  = 1'b1;
    end

    play_n  = (state_n == SIMON) && (state_q != SIMON);
    input_n = (state_n == USER);
  end

  assign state    = state_q;
  assign level    = level_q;
  assign match    = match_q;
  assign text_en  = text_q;
  assign play_req = play_q;
  assign input_en = input_q;

endmodule

// File: tb/tb_msg_sequencer.sv
// tb/tb_msg_sequencer.sv - directed self-checking bench for msg_sequencer
module tb_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, start, seq_done, user_done, user_ok;
  logic [2:0] state, level;
  logic       match, text_en, play_req, input_en;

  int n_pass  = 0;
  int n_total = 0;

  msg_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .start      (start),
    .seq_done   (seq_done),
    .user_done  (user_done),
    .user_ok    (user_ok),
    .state      (state),
    .level      (level),
    .match      (match),
    .text_en    (text_en),
    .play_req   (play_req),
    .input_en   (input_en)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Stimulus drivers: each starts and ends at a falling edge
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_seq();
    seq_done = 1'b1;
    @(negedge clk);
    seq_done = 1'b0;
  endtask

  task automatic pulse_user(input logic ok);
    user_ok   = ok;
    user_done = 1'b1;
    @(negedge clk);
    user_done = 1'b0;
    user_ok   = 1'b0;
  endtask

  task automatic good_round();
    pulse_seq();
    pulse_user(1'b1);
    tick_n(90);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else n_pass++;
    n_total++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else n_pass++;
    n_total++; if ({match, text_en, play_req, input_en} !== 4'b0100)
      $display("FAIL reset_flags got=%b exp=0100", {match, text_en, play_req, input_en}); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blink();
    logic exp_t;
    for (int i = 1; i <= 61; i++) begin
      tick_n(1);
      exp_t = (i < 30 || i >= 60) ? 1'b1 : 1'b0;
      if (i == 29 || i == 30 || i == 59 || i == 60 || i == 61) begin
        n_total++; if (text_en !== exp_t) $display("FAIL blink_tick%0d got=%b exp=%b", i, text_en, exp_t); else n_pass++;
      end
    end
    n_total++; if (state !== 3'd0) $display("FAIL blink_state got=%0d exp=0", state); else n_pass++;
  endtask

  task automatic test_round1();
    pulse_start();
    n_total++; if (state !== 3'd1) $display("FAIL r1_simon got=%0d exp=1", state); else n_pass++;
    n_total++; if (play_req !== 1'b1) $display("FAIL r1_play_hi got=%b exp=1", play_req); else n_pass++;
    n_total++; if (text_en !== 1'b1) $display("FAIL r1_text got=%b exp=1", text_en); else n_pass++;
    @(negedge clk);
    n_total++; if (play_req !== 1'b0) $display("FAIL r1_play_lo got=%b exp=0", play_req); else n_pass++;
    pulse_seq();
    n_total++; if (state !== 3'd2 || input_en !== 1'b1)
      $display("FAIL r1_user got=%0d/%b exp=2/1", state, input_en); else n_pass++;
    pulse_user(1'b1);
    n_total++; if (state !== 3'd3 || match !== 1'b1 || input_en !== 1'b0)
      $display("FAIL r1_result got=%0d/%b/%b exp=3/1/0", state, match, input_en); else n_pass++;
    tick_n(89);
    n_total++; if (state !== 3'd3) $display("FAIL r1_hold89 got=%0d exp=3", state); else n_pass++;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_total++; if (state !== 3'd1 || level !== 3'd1 || play_req !== 1'b1)
      $display("FAIL r1_next got=%0d/%0d/%b exp=1/1/1", state, level, play_req); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_fail_level2();
    good_round();
    n_total++; if (level !== 3'd2 || state !== 3'd1) $display("FAIL f2_level got=%0d/%0d exp=2/1", level, state); else n_pass++;
    pulse_seq();
    pulse_user(1'b0);
    n_total++; if (state !== 3'd3 || match !== 1'b0) $display("FAIL f2_match got=%0d/%b exp=3/0", state, match); else n_pass++;
    tick_n(90);
    n_total++; if (state !== 3'd0 || level !== 3'd2) $display("FAIL f2_ready got=%0d/%0d exp=0/2", state, level); else n_pass++;
    pulse_start();
    n_total++; if (state !== 3'd1 || level !== 3'd0) $display("FAIL f2_restart got=%0d/%0d exp=1/0", state, level); else n_pass++;
  endtask

  task automatic test_win();
    for (int r = 0; r < 5; r++) good_round();
    n_total++; if (level !== 3'd5 || state !== 3'd1) $display("FAIL w_level5 got=%0d/%0d exp=5/1", level, state); else n_pass++;
    good_round();
    n_total++; if (state !== 3'd4 || level !== 3'd5 || match !== 1'b1)
      $display("FAIL w_win got=%0d/%0d/%b exp=4/5/1", state, level, match); else n_pass++;
    n_total++; if (play_req !== 1'b0 || input_en !== 1'b0)
      $display("FAIL w_flags got=%b/%b exp=0/0", play_req, input_en); else n_pass++;
    pulse_start();
    n_total++; if (state !== 3'd1 || level !== 3'd0 || match !== 1'b0)
      $display("FAIL w_restart got=%0d/%0d/%b exp=1/0/0", state, level, match); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stray();
    pulse_user(1'b1);
    n_total++; if (state !== 3'd1 || match !== 1'b0) $display("FAIL s_user_in_simon got=%0d/%b exp=1/0", state, match); else n_pass++;
    pulse_seq();
    pulse_start();
    n_total++; if (state !== 3'd2 || level !== 3'd0 || play_req !== 1'b0)
      $display("FAIL s_start_in_user got=%0d/%0d/%b exp=2/0/0", state, level, play_req); else n_pass++;
    pulse_user(1'b0);
    tick_n(90);
    pulse_seq();
    pulse_user(1'b1);
    n_total++; if (state !== 3'd0 || match !== 1'b0 || input_en !== 1'b0)
      $display("FAIL s_in_ready got=%0d/%b/%b exp=0/0/0", state, match, input_en); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic bad;
    pulse_start();
    good_round();
    pulse_seq();
    pulse_user(1'b1);
    tick_n(45);
    n_total++; if (state !== 3'd3 || level !== 3'd1) $display("FAIL m_pre got=%0d/%0d exp=3/1", state, level); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (state !== 3'd0 || level !== 3'd0 || {match, text_en, play_req, input_en} !== 4'b0100)
      $display("FAIL m_reset got=%0d/%0d/%b exp=0/0/0100", state, level, {match, text_en, play_req, input_en}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) frame_tick = 1'b1; else frame_tick = 1'b0;
      @(negedge clk);
      if (play_req !== 1'b0 || state !== 3'd0) bad = 1'b1;
    end
    frame_tick = 1'b0;
    n_total++; if (bad !== 1'b0) $display("FAIL m_no_pulse got=%b exp=0", bad); else n_pass++;
    pulse_start();
    n_total++; if (state !== 3'd1 || play_req !== 1'b1) $display("FAIL m_after got=%0d/%b exp=1/1", state, play_req); else n_pass++;
  endtask

  initial begin
    frame_tick = 1'b0;
    start      = 1'b0;
    seq_done   = 1'b0;
    user_done  = 1'b0;
    user_ok    = 1'b0;
    @(negedge clk);
    test_reset();
    test_blink();
    test_round1();
    test_fail_level2();
    test_win();
    test_stray();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
